count_bcd_display: RTL and testbench
====================================

Name: count_bcd_display

Overview:
- Downstream consumer of the 8-bit up/down counter's `out` bus.
- Repeatedly samples the counter value and converts it to 3-digit BCD with a sequential double-dabble (shift-add-3) engine.
- Drives a time-multiplexed 3-digit 7-segment display with leading-zero blanking.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 4: clock cycles per digit-scan slot; legal range >= 2.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0 (common anode); 0 = lit when its bit is 1.
- LZB_EN, 1: 1 = leading-zero blanking enabled; 0 = all three digits always shown.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- value  input  8  unsigned counter value; sampled only in IDLE.
- bcd  output  12  last converted result: {hundreds[11:8], tens[7:4], ones[3:0]}.
- bcd_valid  output  1  one-cycle pulse when bcd updates.
- busy  output  1  high while a conversion is in flight (SHIFT or DONE).
- seg  output  7  segment pattern, bit order {g,f,e,d,c,b,a}.
- an  output  3  one-hot active-high digit enable: bit0 = ones, bit1 = tens, bit2 = hundreds.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset. All state clears immediately on reset assertion, independent of clk.
- Reset values:
  - state = IDLE; bcd = 12'h000; bcd_valid = 0; busy = 0.
  - Scan prescaler = 0; digit index = 0; an = 3'b001.
  - seg = glyph "0": 7'b1000000 when SEG_ACTIVE_LOW = 1, else 7'b0111111.
- Converter FSM:
  - IDLE: on the next edge, latch value into the 20-bit shift register ({12'b0, value}); step counter = 0; go to SHIFT.
  - SHIFT: each edge, first add 3 to every BCD nibble >= 5, then shift the whole register left by 1. Increment the step counter. After the 8th shift, go to DONE.
  - DONE: on the next edge, write bcd from register bits [19:8], pulse bcd_valid for exactly one cycle, return to IDLE.
- Timing:
  - Sample edge E0; shift edges E1..E8; bcd and bcd_valid update at E9.
  - Next sample at E10, so a new result arrives every 10 cycles.
  - Changes to value outside IDLE are ignored; no data is skipped mid-conversion.
- busy is high from the cycle after E0 through the cycle in which bcd_valid is high.
- Results: hundreds nibble is only ever 0–2; tens and ones nibbles are always 0–9. 8'd255 converts to 12'h255.
- Reset mid-conversion aborts the conversion: bcd returns to 000 and no bcd_valid pulse is produced.
- Display scan:
  - A free-running prescaler advances the digit index every SCAN_DIV cycles, in the order 0 → 1 → 2 → 0.
  - an and seg are registered and change on the same edge as the index.
  - The display always shows the current bcd register. A bcd update mid-slot takes effect at the next slot boundary.
- Glyph decode:
  - Standard 0–9 glyphs; seg is inverted when SEG_ACTIVE_LOW = 1.
  - Nibble values 10–15 cannot occur; if they do, decode to all segments off.
- Blanking (LZB_EN = 1):
  - Hundreds digit is blanked (all segments off) when its nibble is 0.
  - Tens digit is blanked when both hundreds and tens are 0.
  - Ones digit is never blanked.
  - While a digit is blanked, an still selects it.

Test Plan:
- Reset held 3 cycles, value = 8'd200: bcd = 000, bcd_valid = 0, an = 001, seg = 1000000. After release, first bcd_valid occurs on the 10th edge with bcd = 12'h200.
- value held at 8'd255: bcd = 12'h255 with bcd_valid pulses exactly 10 cycles apart. Scan sees an 001/010/100 with seg glyphs 5, 5, 2, each held SCAN_DIV cycles.
- value = 8'd7: bcd = 12'h007. Hundreds and tens slots show seg = 1111111 (blanked); ones slot shows 7 = 1111000. With LZB_EN = 0, the leading slots show 0 = 1000000.
- value = 8'd100: bcd = 12'h100; tens slot shows 0 (not blanked, because hundreds is nonzero).
- value changes 8'd10 → 8'd11 on the cycle after the sample edge: that conversion yields 12'h010; the next conversion yields 12'h011.
- Reset pulsed during SHIFT step 4: bcd = 000, busy = 0 immediately, no bcd_valid pulse; normal 10-cycle conversions resume after release.

Source files
------------

// File: rtl/count_bcd_display.sv
// Samples the counter value, converts it to BCD with a sequential double-dabble engine,
// and scans the result onto a 3-digit multiplexed 7-segment display.
module count_bcd_display #(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZB_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_r;
  logic [19:0]   sr_r;
  logic [3:0]    step_r;
  logic [PW-1:0] pre_r;
  logic [1:0]    idx_r;
  logic [1:0]    idx_nx_s;
  logic [3:0]    nib_s;
  logic          blank_s;

  // One double-dabble step: correct every BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] a;
    a = r;
    for (int i = 0; i < 3; i++) begin
      if (a[8+4*i +: 4] >= 4'd5) begin
        a[8+4*i +: 4] = a[8+4*i +: 4] + 4'd3;
      end else begin
        a[8+4*i +: 4] = a[8+4*i +: 4];
      end
    end
    return {a[18:0], 1'b0};
  endfunction

  // Glyph in {g,f,e,d,c,b,a} order, polarity applied; illegal nibbles and blanking give all-off.
  function automatic logic [6:0] glyph(input logic [3:0] d, input logic blank);
    logic [6:0] g;
    if (blank) begin
      g = 7'b0000000;
    end else begin
      case (d)
        4'd0:    g = 7'b0111111;
        4'd1:    g = 7'b0000110;
        4'd2:    g = 7'b1011011;
        4'd3:    g = 7'b1001111;
        4'd4:    g = 7'b1100110;
        4'd5:    g = 7'b1101101;
        4'd6:    g = 7'b1111101;
        4'd7:    g = 7'b0000111;
        4'd8:    g = 7'b1111111;
        4'd9:    g = 7'b1101111;
        default: g = 7'b0000000;
      endcase
    end
    return SEG_ACTIVE_LOW ? ~g : g;
  endfunction

  // Select the digit (and its blanking) for the slot about to start.
  always_comb begin
    idx_nx_s = (idx_r == 2'd2) ? 2'd0 : idx_r + 2'd1;
    nib_s    = 4'd0;
    blank_s  = 1'b0;
    case (idx_nx_s)
      2'd0: begin
        nib_s   = bcd[3:0];
        blank_s = 1'b0;
      end
      2'd1: begin
        nib_s   = bcd[7:4];
        blank_s = LZB_EN && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        nib_s   = bcd[11:8];
        blank_s = LZB_EN && (bcd[11:8] == 4'd0);
      end
      default: begin
        nib_s   = 4'd0;
        blank_s = 1'b1;
      end
    endcase
  end

  // Converter FSM: sample in IDLE, eight shift-add-3 steps, publish in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      sr_r      <= 20'd0;
      step_r    <= 4'd0;
      bcd       <= 12'h000;
      bcd_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          sr_r      <= {12'd0, value};
          step_r    <= 4'd0;
          bcd_valid <= 1'b0;
          busy      <= 1'b1;
          state_r   <= SHIFT;
        end
        SHIFT: begin
          sr_r      <= dabble_step(sr_r);
          step_r    <= step_r + 4'd1;
          bcd_valid <= 1'b0;
          busy      <= 1'b1;
          state_r   <= (step_r == 4'd7) ? DONE : SHIFT;
        end
        DONE: begin
          bcd       <= sr_r[19:8];
          bcd_valid <= 1'b1;
          busy      <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          bcd_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  // Free-running scan: advance the digit and reload an/seg at each slot boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_r <= '0;
      idx_r <= 2'd0;
      an    <= 3'b001;
      seg   <= glyph(4'd0, 1'b0);
    end else if (pre_r == PW'(SCAN_DIV - 1)) begin
      pre_r <= '0;
      idx_r <= idx_nx_s;
      an    <= 3'b001 << idx_nx_s;
      seg   <= glyph(nib_s, blank_s);
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

endmodule

// File: tb/tb_count_bcd_display.sv
// Bench for count_bcd_display: arithmetic reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_count_bcd_display;

  localparam int SD = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  value = 8'd200;
  logic [11:0] bcd, bcd1;
  logic        bcd_valid, bcd_valid1, busy, busy1;
  logic [6:0]  seg, seg1;
  logic [2:0]  an, an1;

  count_bcd_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZB_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd), .bcd_valid(bcd_valid),
    .busy(busy), .seg(seg), .an(an)
  );

  count_bcd_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1), .LZB_EN(1'b0)) dut_nolzb (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd1), .bcd_valid(bcd_valid1),
    .busy(busy1), .seg(seg1), .an(an1)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-high glyphs for decimal digits, {g,f,e,d,c,b,a}.
  logic [6:0] hi_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [6:0] disp(input int v, input int idx, input bit lzb);
    int d;
    bit blank;
    d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
    blank = lzb && ((idx == 2 && v < 100) || (idx == 1 && v < 10));
    return blank ? 7'h7F : ~hi_tab[d];
  endfunction

  // Reference model: edges counted from reset release; samples every 10 edges starting at edge 1.
  int         m_n = 0;
  int         m_pend = 0;
  int         m_val = 0;
  bit         m_valid = 0;
  bit         m_busy = 0;
  logic [2:0] m_an = 3'b001;
  logic [6:0] m_seg0 = 7'b1000000;
  logic [6:0] m_seg1 = 7'b1000000;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_n = 0; m_pend = 0; m_val = 0; m_valid = 0; m_busy = 0;
      m_an = 3'b001; m_seg0 = disp(0, 0, 1'b1); m_seg1 = disp(0, 0, 1'b0);
    end else begin
      m_n++;
      if (m_n % SD == 0) begin
        m_an   = 3'b001 << ((m_n / SD) % 3);
        m_seg0 = disp(m_val, (m_n / SD) % 3, 1'b1);
        m_seg1 = disp(m_val, (m_n / SD) % 3, 1'b0);
      end
      if (m_n % 10 == 1) m_pend = int'(value);
      m_valid = (m_n % 10 == 0);
      if (m_valid) m_val = m_pend;
      m_busy = 1'b1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("bcd", bcd, {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)});
    chk("bcd_valid", bcd_valid, m_valid);
    chk("busy", busy, m_busy);
    chk("an", an, m_an);
    chk("seg", seg, m_seg0);
    chk("seg_nolzb", seg1, m_seg1);
  end

  task automatic wait_valid(input string name, output int edges);
    bit found = 0;
    edges = 0;
    for (int i = 1; i <= 30 && !found; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1) begin
        found = 1;
        edges = i;
      end
    end
    if (!found) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_bcd(input string name, input logic [11:0] exp);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bcd_valid === 1'b1 && bcd === exp) found = 1;
    end
    chk(name, found, 1);
  endtask

  task automatic check_slots(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] f0, input logic [6:0] f1,
                             input logic [6:0] f2);
    for (int i = 0; i < 3 * SD; i++) begin
      @(negedge clk);
      chk({tag, "_an_onehot"}, $onehot(an), 1);
      case (an)
        3'b001: begin chk({tag, "_ones"}, seg, e0); chk({tag, "_ones_nolzb"}, seg1, f0); end
        3'b010: begin chk({tag, "_tens"}, seg, e1); chk({tag, "_tens_nolzb"}, seg1, f1); end
        3'b100: begin chk({tag, "_hund"}, seg, e2); chk({tag, "_hund_nolzb"}, seg1, f2); end
        default: ;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int run;
    bit seen;
    logic [2:0] prev;

    // Reset held three cycles with value 200.
    value = 8'd200;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_valid", bcd_valid, 0);
    chk("rst_an", an, 3'b001);
    chk("rst_seg", seg, 7'b1000000);
    #2 reset = 1'b0;
    wait_valid("first", edges);
    chk("first_latency", edges, 10);
    chk("first_bcd", bcd, 12'h200);

    // 255: steady 10-cycle cadence and scanned glyphs 5,5,2.
    #2 value = 8'd255;
    wait_valid("v255a", edges);
    chk("v255a_gap", edges, 10);
    chk("v255a_bcd", bcd, 12'h255);
    wait_valid("v255b", edges);
    chk("v255b_gap", edges, 10);
    chk("v255b_bcd", bcd, 12'h255);
    prev = an; run = 0; seen = 0;
    for (int i = 0; i < 6 * SD; i++) begin
      @(negedge clk);
      if (an == 3'b001) chk("v255_ones", seg, 7'b0010010);
      else if (an == 3'b010) chk("v255_tens", seg, 7'b0010010);
      else chk("v255_hund", seg, 7'b0100100);
      if (an == prev) run++;
      else begin
        if (seen) chk("slot_len", run, SD);
        seen = 1; run = 1; prev = an;
      end
    end

    // 7: leading digits blanked; without blanking they show 0.
    #2 value = 8'd7;
    wait_bcd("v7_bcd", 12'h007);
    repeat (3 * SD) @(negedge clk);
    check_slots("v7", 7'b1111000, 7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000, 7'b1000000);

    // 100: tens zero is shown because hundreds is nonzero.
    #2 value = 8'd100;
    wait_bcd("v100_bcd", 12'h100);
    repeat (3 * SD) @(negedge clk);
    check_slots("v100", 7'b1000000, 7'b1000000, 7'b1111001, 7'b1000000, 7'b1000000, 7'b1111001);

    // 10 -> 11 changed right after the sample edge.
    #2 value = 8'd10;
    wait_bcd("v10_settle", 12'h010);
    @(negedge clk);
    chk("v10_at_sample", m_n % 10, 1);
    #2 value = 8'd11;
    wait_valid("v10_hold", edges);
    chk("v10_hold_bcd", bcd, 12'h010);
    wait_valid("v11", edges);
    chk("v11_bcd", bcd, 12'h011);

    // Reset asserted during shift step 4.
    #2 value = 8'd123;
    wait_bcd("v123_bcd", 12'h123);
    for (int i = 0; i < 12 && (m_n % 10) != 5; i++) @(negedge clk);
    chk("mid_phase", m_n % 10, 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_bcd", bcd, 12'h000);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bcd_valid, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_valid("resume", edges);
    chk("resume_latency", edges, 10);
    chk("resume_bcd", bcd, 12'h123);
    wait_valid("resume2", edges);
    chk("resume2_gap", edges, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
